fetch_unit: RTL and testbench

//  IF-stage producer for the IF/ID register: generates the PC sequence, issues requests to instruction memory,

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the prefetch buffer entry layout for fetch_unit
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x entry_t FIFO with push/pop/flush, combinational head and occupancy count
//   push_i/din_i write, pop_i advances head, flush_i empties, head_o current head, count_o occupancy
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  entry_t                 din_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0] cnt_q, cnt_d;
  entry_t mem_q [DEPTH];
  always_comb begin
    rp_d  = flush_i ? '0 : rp_q + AW'(pop_i);
    wp_d  = flush_i ? '0 : wp_q + AW'(push_i);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end
  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC sequencer, imem request issue and prefetch buffer feeding reg_fd
//   imem_* request/response interface, stall_f hold, pcsrc_e/pctarget_e redirect,
//   rd/pc_f/pcplus4_f/valid_f to reg_fd; FETCH_PERF_EN adds bubble_cnt output
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        pcsrc_e,
  input  logic [31:0] pctarget_e,
  output logic [31:0] rd,
  output logic [31:0] pc_f,
  output logic [31:0] pcplus4_f,
  output logic        valid_f
`ifdef FETCH_PERF_EN
  ,output logic [31:0] bubble_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count;
  logic [CW:0] occupancy;
  logic xfer, drop, push, pop;
  entry_t head;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({resp_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (pcsrc_e),
    .head_o  (head),
    .count_o (count)
  );
  // buffered plus in-flight words bound the issue rate, so a response always has a free slot
  assign occupancy = {1'b0, count} + {1'b0, inflight_q};
  assign imem_req  = ~rst & ~pcsrc_e & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign xfer      = imem_req & imem_gnt;
  assign drop      = imem_rvalid & (discard_q != '0);
  assign push      = imem_rvalid & ~drop & ~pcsrc_e;
  assign pop       = valid_f & ~stall_f & ~pcsrc_e;
  assign target    = pctarget_e & ~32'h3;
  assign valid_f   = count != '0;
  assign rd        = valid_f ? head.instr : NOP_INSTR;
  assign pc_f      = valid_f ? head.pc : '0;
  assign pcplus4_f = pc_f + 32'd4;
  always_comb begin
    inflight_d = inflight_q + CW'(xfer) - CW'(imem_rvalid);
    // every response still owed at a redirect is wrong-path, including one landing this cycle
    discard_d  = pcsrc_e ? inflight_q - CW'(imem_rvalid) : discard_q - CW'(drop);
    fetch_pc_d = pcsrc_e ? target : xfer ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = pcsrc_e ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q;
  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else if (~stall_f & ~valid_f & ~&bubble_q) bubble_q <= bubble_q + 32'd1;
  end
  assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an in-order imem model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk = 0, rst = 1, rst_w = 1;
  always #5 clk = ~clk;
  logic imem_req, imem_gnt, imem_rvalid = 0, stall_f = 0, pcsrc_e = 0, valid_f;
  logic [31:0] imem_addr, imem_rdata = 0, pctarget_e = 0, rd, pc_f, pcplus4_f;
  logic req_w, rvalid_w = 0, valid_w;
  logic [31:0] addr_w, rdata_w = 0, rd_w, pc_w, pcplus4_w;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt, bubble_w;
`endif
  int checks = 0, failures = 0;
  bit gnt_en = 1, rand_gnt = 0, gnt_bit = 1;
  int lat_min = 1, lat_max = 1, cyc = 0, last_t = 0, t;
  logic [31:0] q_a[$];
  int q_t[$];
  assign imem_gnt = gnt_en & gnt_bit;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_f(stall_f), .pcsrc_e(pcsrc_e),
    .pctarget_e(pctarget_e), .rd(rd), .pc_f(pc_f), .pcplus4_f(pcplus4_f), .valid_f(valid_f)
`ifdef FETCH_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_req(req_w), .imem_addr(addr_w), .imem_gnt(1'b1),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w), .stall_f(1'b0), .pcsrc_e(1'b0),
    .pctarget_e(32'h0), .rd(rd_w), .pc_f(pc_w), .pcplus4_f(pcplus4_w), .valid_f(valid_w)
`ifdef FETCH_PERF_EN
    , .bubble_cnt(bubble_w)
`endif
  );

  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction

  // in-order memory returning the address as data; latency lat_min..lat_max, one response per cycle
  always @(posedge clk) begin
    gnt_bit <= rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc <= cyc + 1;
    if (rst) begin
      q_a.delete();
      q_t.delete();
      imem_rvalid <= 0;
      last_t <= 0;
    end else begin
      if (imem_req && imem_gnt) begin
        t = mx(cyc + int'($urandom_range(lat_min, lat_max)) - 1, last_t + 1);
        q_a.push_back(imem_addr);
        q_t.push_back(t);
        last_t <= t;
      end
      if (q_t.size() > 0 && q_t[0] <= cyc) begin
        imem_rvalid <= 1;
        imem_rdata <= q_a.pop_front();
        void'(q_t.pop_front());
      end else imem_rvalid <= 0;
    end
  end

  always @(posedge clk) begin
    rvalid_w <= req_w;
    rdata_w <= addr_w;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1; stall_f = 0; pcsrc_e = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (valid_f !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (valid_f !== 1'b1) begin checks++; failures++; $display("FAIL %s_timeout got=%b exp=1", nm, valid_f); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_f !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_f); end
    checks++; if (rd !== NOP_INSTR) begin failures++; $display("FAIL rst_rd got=%h exp=%h", rd, NOP_INSTR); end
    checks++; if (pc_f !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_f); end
    checks++; if (pcplus4_f !== 32'h4) begin failures++; $display("FAIL rst_pcplus4 got=%h exp=4", pcplus4_f); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
`ifdef FETCH_PERF_EN
    checks++; if (bubble_cnt !== 32'h0) begin failures++; $display("FAIL rst_bubble got=%0d exp=0", bubble_cnt); end
`endif
    rst = 0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (valid_f !== 1'b0) begin failures++; $display("FAIL valid_cyc1 got=%b exp=0", valid_f); end
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL addr_cyc1 got=%h exp=4", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (valid_f !== 1'b1 || pc_f !== 32'(4*i) || rd !== 32'(4*i)) begin failures++; $display("FAIL seq%0d got=%b/%h/%h exp=1/%h/%h", i, valid_f, pc_f, rd, 4*i, 4*i); end
    end
    checks++; if (pcplus4_f !== 32'hC) begin failures++; $display("FAIL seq_pcplus4 got=%h exp=c", pcplus4_f); end
  endtask

  task automatic test_stall();
    logic [31:0] p, e;
    int seen = 0;
    p = pc_f;
    stall_f = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid_f !== 1'b1 || pc_f !== p || rd !== p) begin failures++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/%h/%h", i, valid_f, pc_f, rd, p, p); end
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req_full got=%b exp=0", imem_req); end
    stall_f = 0;
    e = p;
    for (int i = 0; i < 10; i++) begin
      if (valid_f === 1'b1) begin
        seen++;
        checks++; if (pc_f !== e || rd !== e) begin failures++; $display("FAIL stall_release pc got=%h/%h exp=%h", pc_f, rd, e); end
        e = pc_f + 32'd4;
      end
      @(negedge clk);
    end
    checks++; if (seen < 9) begin failures++; $display("FAIL stall_release_rate got=%0d exp>=9", seen); end
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3;
    repeat (6) @(negedge clk);
    pcsrc_e = 1; pctarget_e = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got=%b exp=0", imem_req); end
    @(negedge clk);
    pcsrc_e = 0;
    checks++; if (valid_f !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", valid_f); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
    wait_valid("redir");
    checks++; if (pc_f !== 32'h100 || pcplus4_f !== 32'h104 || rd !== 32'h100) begin failures++; $display("FAIL redir_first got=%h/%h/%h exp=100/104/100", pc_f, pcplus4_f, rd); end
    @(negedge clk);
    wait_valid("redir2");
    checks++; if (pc_f !== 32'h104) begin failures++; $display("FAIL redir_second got=%h exp=104", pc_f); end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_misaligned();
    pcsrc_e = 1; pctarget_e = 32'h103;
    @(negedge clk);
    pcsrc_e = 0;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL misal_addr got=%h exp=100", imem_addr); end
    wait_valid("misal");
    checks++; if (pc_f !== 32'h100 || rd !== 32'h100) begin failures++; $display("FAIL misal_first got=%h/%h exp=100/100", pc_f, rd); end
    @(negedge clk);
    wait_valid("misal2");
    checks++; if (pc_f !== 32'h104) begin failures++; $display("FAIL misal_second got=%h exp=104", pc_f); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int n = 0;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    rst_w = 1;
    repeat (2) @(negedge clk);
    rst_w = 0;
    while (valid_w !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++; if (valid_w !== 1'b1 || pc_w !== exp_pc[i] || rd_w !== exp_pc[i]) begin failures++; $display("FAIL wrap%0d got=%b/%h/%h exp=1/%h", i, valid_w, pc_w, rd_w, exp_pc[i]); end
      if (i == 1) begin
        checks++; if (pcplus4_w !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4 got=%h exp=0", pcplus4_w); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    do_reset();
    rand_gnt = 1; lat_min = 1; lat_max = 4;
    rst = 0;
    e = RESET_PC_DEF;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid_f === 1'b1) begin
        checks++; if (pc_f !== e) begin failures++; $display("FAIL rand_pc cyc%0d got=%h exp=%h", i, pc_f, e); end
        checks++; if (rd !== pc_f || pcplus4_f !== pc_f + 32'd4) begin failures++; $display("FAIL rand_data cyc%0d got=%h/%h exp=%h/%h", i, rd, pcplus4_f, pc_f, pc_f + 32'd4); end
      end
      stall_f = $urandom_range(0, 9) < 3;
      pcsrc_e = $urandom_range(0, 99) < 3;
      pctarget_e = $urandom;
      if (pcsrc_e) e = pctarget_e & ~32'h3;
      else if (valid_f === 1'b1 && !stall_f) e = pc_f + 32'd4;
    end
    stall_f = 0; pcsrc_e = 0; rand_gnt = 0; lat_min = 1; lat_max = 1;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    gnt_en = 0;
    do_reset();
    checks++; if (bubble_cnt !== 32'd0) begin failures++; $display("FAIL perf_rst got=%0d exp=0", bubble_cnt); end
    rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (bubble_cnt !== 32'd3 || valid_f !== 1'b0) begin failures++; $display("FAIL perf_empty got=%0d/%b exp=3/0", bubble_cnt, valid_f); end
    stall_f = 1;
    repeat (2) @(negedge clk);
    checks++; if (bubble_cnt !== 32'd3) begin failures++; $display("FAIL perf_stalled got=%0d exp=3", bubble_cnt); end
    stall_f = 0; gnt_en = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
